// File: rtl/ram_dp_pkg.sv
// Shared constants, clear-FSM state encoding and configuration helpers for ram_dp_asym.
package ram_dp_pkg;

    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;
    localparam int NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int mem_bits, input int width_a, input int width_b);
        return is_pow2(mem_bits) && is_pow2(width_a) && is_pow2(width_b) &&
               (width_a <= width_b) && ((mem_bits % width_b) == 0);
    endfunction

endpackage

// File: rtl/ram_dp_clr_fsm.sv
// Post-reset clear sequencer: walks every wide word once, writing zero, and flags BUSY meanwhile.
module ram_dp_clr_fsm
    import ram_dp_pkg::*;
#(
    parameter int DEPTH_B        = 256,
    parameter int AW_B           = 8,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            busy,
    output logic [AW_B-1:0] clr_addr,
    output logic            clr_we,
    output clr_state_t      state
);

    localparam clr_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_DONE;

    clr_state_t      state_nx;
    logic [AW_B-1:0] addr_nx;

    // busy trails the state by one edge so it stays high through the final clear write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_addr <= addr_nx;
            busy     <= (state == CLR_CLEAR);
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = clr_addr;
        clr_we   = 1'b0;
        case (state)
            CLR_CLEAR: begin
                clr_we  = 1'b1;
                addr_nx = clr_addr + 1'b1;
                if (clr_addr == AW_B'(DEPTH_B - 1)) state_nx = CLR_DONE;
            end
            CLR_IDLE: state_nx = CLR_DONE;
            default:  state_nx = state;
        endcase
    end

endmodule

// File: rtl/ram_dp_asym.sv
// Single-clock true dual-port RAM, narrow port A and lane-writable wide port B,
// with per-port write modes, optional output register, collision flag and optional clear.
module ram_dp_asym
    import ram_dp_pkg::*;
#(
    parameter int MEM_BITS       = 4096,
    parameter int WIDTH_A        = 8,
    parameter int WIDTH_B        = 16,
    parameter int WRITE_MODE_A   = WRITE_FIRST,
    parameter int WRITE_MODE_B   = WRITE_FIRST,
    parameter int DO_REG         = 0,
    parameter int CLEAR_ON_RESET = 0,
    localparam int RATIO         = WIDTH_B / WIDTH_A,
    localparam int AW_A          = clog2(MEM_BITS / WIDTH_A),
    localparam int AW_B          = clog2(MEM_BITS / WIDTH_B)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               ENA,
    input  logic               WEA,
    input  logic               RSTA,
    input  logic [AW_A-1:0]    ADDRA,
    input  logic [WIDTH_A-1:0] DIA,
    output logic [WIDTH_A-1:0] DOA,
    input  logic               ENB,
    input  logic [RATIO-1:0]   WEB,
    input  logic               RSTB,
    input  logic [AW_B-1:0]    ADDRB,
    input  logic [WIDTH_B-1:0] DIB,
    output logic [WIDTH_B-1:0] DOB,
    output logic               COLL,
    output logic               BUSY
);

    localparam int DEPTH_A = MEM_BITS / WIDTH_A;
    localparam int DEPTH_B = MEM_BITS / WIDTH_B;
    localparam int LW      = (RATIO > 1) ? clog2(RATIO) : 1;

    if (!cfg_ok(MEM_BITS, WIDTH_A, WIDTH_B)) begin : g_bad_cfg
        $error("ram_dp_asym: widths must be powers of two, WIDTH_A <= WIDTH_B, MEM_BITS a multiple of WIDTH_B");
    end

    logic [WIDTH_A-1:0] mem [DEPTH_A];

    logic            busy_q, clr_we, blocked;
    logic [AW_B-1:0] clr_addr;
    clr_state_t      clr_state;

    ram_dp_clr_fsm #(
        .DEPTH_B        (DEPTH_B),
        .AW_B           (AW_B),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk      (CLK),
        .rst_n    (RST_N),
        .busy     (busy_q),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .state    (clr_state)
    );

    assign BUSY    = busy_q;
    assign blocked = (clr_state != CLR_DONE) | busy_q;

    function automatic logic [AW_A-1:0] b_index(input logic [AW_B-1:0] word, input int lane);
        return AW_A'(int'(word) * RATIO + lane);
    endfunction

    logic             ena_e, wea_e, enb_e, coll_nx;
    logic [RATIO-1:0] web_e;
    logic [AW_B-1:0]  a_word;
    logic [LW-1:0]    a_lane;

    assign ena_e = ENA & ~blocked;
    assign wea_e = ena_e & WEA;
    assign enb_e = ENB & ~blocked;
    assign web_e = enb_e ? WEB : '0;

    if (RATIO > 1) begin : g_lanes
        assign a_word = ADDRA[AW_A-1 -: AW_B];
        assign a_lane = ADDRA[LW-1:0];
    end else begin : g_no_lanes
        assign a_word = ADDRA;
        assign a_lane = '0;
    end

    assign coll_nx = ena_e & enb_e & (a_word == ADDRB) & (wea_e | web_e[a_lane]);

    logic [WIDTH_A-1:0] old_a;
    logic [WIDTH_B-1:0] old_b, merged_b;

    always_comb begin
        old_a = mem[ADDRA];
        for (int k = 0; k < RATIO; k++) begin
            old_b[k*WIDTH_A +: WIDTH_A]    = mem[b_index(ADDRB, k)];
            merged_b[k*WIDTH_A +: WIDTH_A] = WEB[k] ? DIB[k*WIDTH_A +: WIDTH_A]
                                                    : mem[b_index(ADDRB, k)];
        end
    end

    // The clear sequence borrows port B; port B is written last so it wins a shared lane.
    logic [AW_B-1:0]    wb_addr;
    logic [RATIO-1:0]   wb_lanes;
    logic [WIDTH_B-1:0] wb_data;

    assign wb_addr  = clr_we ? clr_addr : ADDRB;
    assign wb_lanes = clr_we ? '1 : web_e;
    assign wb_data  = clr_we ? '0 : DIB;

    always_ff @(posedge CLK) begin
        if (wea_e) mem[ADDRA] <= DIA;
        for (int k = 0; k < RATIO; k++) begin
            if (wb_lanes[k]) mem[b_index(wb_addr, k)] <= wb_data[k*WIDTH_A +: WIDTH_A];
        end
    end

    logic [WIDTH_A-1:0] rd_a_q, rd_a_nx;
    logic [WIDTH_B-1:0] rd_b_q, rd_b_nx;
    logic               coll_q;

    // A reading port always sees the pre-edge array, which also covers the collision case.
    always_comb begin
        rd_a_nx = rd_a_q;
        rd_b_nx = rd_b_q;
        if (ena_e) begin
            if (RSTA)                               rd_a_nx = '0;
            else if (!WEA)                          rd_a_nx = old_a;
            else if (WRITE_MODE_A == WRITE_FIRST)   rd_a_nx = DIA;
            else if (WRITE_MODE_A == READ_FIRST)    rd_a_nx = old_a;
        end
        if (enb_e) begin
            if (RSTB)                               rd_b_nx = '0;
            else if (WEB == '0)                     rd_b_nx = old_b;
            else if (WRITE_MODE_B == WRITE_FIRST)   rd_b_nx = merged_b;
            else if (WRITE_MODE_B == READ_FIRST)    rd_b_nx = old_b;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            coll_q <= 1'b0;
        end else begin
            rd_a_q <= rd_a_nx;
            rd_b_q <= rd_b_nx;
            coll_q <= coll_nx;
        end
    end

    assign COLL = coll_q;

    if (DO_REG != 0) begin : g_do_reg
        logic [WIDTH_A-1:0] do_a_q;
        logic [WIDTH_B-1:0] do_b_q;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                do_a_q <= '0;
                do_b_q <= '0;
            end else begin
                do_a_q <= rd_a_q;
                do_b_q <= rd_b_q;
            end
        end
        assign DOA = do_a_q;
        assign DOB = do_b_q;
    end else begin : g_no_do_reg
        assign DOA = rd_a_q;
        assign DOB = rd_b_q;
    end

endmodule

// File: tb/tb_ram_dp_asym.sv
// Bench for ram_dp_asym: three configurations driven in lockstep against a byte-array reference model.
module tb_ram_dp_asym;
    import ram_dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, wea, rsta, enb, rstb;
    logic [8:0]  addra;
    logic [7:0]  dia;
    logic [1:0]  web;
    logic [7:0]  addrb;
    logic [15:0] dib;

    logic [7:0]  doa  [3];
    logic [15:0] dob  [3];
    logic        coll [3];
    logic        busy [3];

    always #5 clk = ~clk;

    // u0: defaults with clear; u1: A read-first, B no-change, output register; u2: A no-change, B read-first
    ram_dp_asym #(.CLEAR_ON_RESET(1)) u0 (
        .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(doa[0]),
        .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(dob[0]), .COLL(coll[0]), .BUSY(busy[0]));
    ram_dp_asym #(.WRITE_MODE_A(READ_FIRST), .WRITE_MODE_B(NO_CHANGE), .DO_REG(1)) u1 (
        .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(doa[1]),
        .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(dob[1]), .COLL(coll[1]), .BUSY(busy[1]));
    ram_dp_asym #(.WRITE_MODE_A(NO_CHANGE), .WRITE_MODE_B(READ_FIRST)) u2 (
        .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(doa[2]),
        .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(dob[2]), .COLL(coll[2]), .BUSY(busy[2]));

    int mode_a [3] = '{WRITE_FIRST, READ_FIRST, NO_CHANGE};
    int mode_b [3] = '{WRITE_FIRST, NO_CHANGE, READ_FIRST};
    bit dreg   [3] = '{1'b0, 1'b1, 1'b0};

    logic [7:0]  m_mem  [3][512];
    logic [7:0]  m_s1a  [3];
    logic [7:0]  m_s2a  [3];
    logic [15:0] m_s1b  [3];
    logic [15:0] m_s2b  [3];
    logic        m_coll [3];
    int          clr_n = 0;

    int checks = 0;
    int errors = 0;
    int busy_len;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; rsta = 1'b0; addra = '0; dia = '0;
        enb = 1'b0; web = '0;   rstb = 1'b0; addrb = '0; dib = '0;
    endtask

    // One clock edge of the reference: reads see the array before this edge, B stores after A.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            logic [7:0]  oa;
            logic [15:0] ob, nb;
            bit          ea, eb;
            if (!rst_n) begin
                m_s1a[d] = '0; m_s2a[d] = '0; m_s1b[d] = '0; m_s2b[d] = '0; m_coll[d] = 1'b0;
                // u0 is guaranteed all-zero once its (re)started clear completes
                if (d == 0) for (int i = 0; i < 512; i++) m_mem[0][i] = '0;
            end else begin
                ea = ena && !(d == 0 && clr_n <= 256);
                eb = enb && !(d == 0 && clr_n <= 256);
                oa = m_mem[d][addra];
                ob = {m_mem[d][{addrb, 1'b1}], m_mem[d][{addrb, 1'b0}]};
                nb = ob;
                if (web[0]) nb[7:0]  = dib[7:0];
                if (web[1]) nb[15:8] = dib[15:8];
                m_s2a[d] = m_s1a[d];
                m_s2b[d] = m_s1b[d];
                if (ea) begin
                    if (rsta)                                   m_s1a[d] = '0;
                    else if (!wea || mode_a[d] == READ_FIRST)   m_s1a[d] = oa;
                    else if (mode_a[d] == WRITE_FIRST)          m_s1a[d] = dia;
                end
                if (eb) begin
                    if (rstb)                                        m_s1b[d] = '0;
                    else if (web == 2'b00 || mode_b[d] == READ_FIRST) m_s1b[d] = ob;
                    else if (mode_b[d] == WRITE_FIRST)               m_s1b[d] = nb;
                end
                m_coll[d] = ea && eb && (addra[8:1] == addrb) && (wea || web[addra[0]]);
                if (ea && wea)     m_mem[d][addra] = dia;
                if (eb && web[0])  m_mem[d][{addrb, 1'b0}] = dib[7:0];
                if (eb && web[1])  m_mem[d][{addrb, 1'b1}] = dib[15:8];
            end
        end
        if (!rst_n) clr_n = 0;
        else if (clr_n < 100000) clr_n++;
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d_doa", d),  16'(doa[d]), 16'(dreg[d] ? m_s2a[d] : m_s1a[d]));
            chk($sformatf("u%0d_dob", d),  dob[d],      dreg[d] ? m_s2b[d] : m_s1b[d]);
            chk($sformatf("u%0d_coll", d), 16'(coll[d]), 16'(m_coll[d]));
            chk($sformatf("u%0d_busy", d), 16'(busy[d]), 16'(d == 0 && clr_n >= 1 && clr_n <= 256));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (100) cycle();

        // restart the clear part-way through
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        busy_len = 0;
        cycle();
        if (busy[0] === 1'b1) busy_len++;
        // u0 must ignore these; they seed the uncleared arrays of u1 and u2
        for (int i = 0; i < 256; i++) begin
            enb = 1'b1; web = 2'b11; addrb = 8'(i); dib = 16'($urandom_range(0, 65535));
            cycle();
            if (busy[0] === 1'b1) busy_len++;
        end
        idle();
        repeat (3) begin
            cycle();
            if (busy[0] === 1'b1) busy_len++;
        end
        chk("busy_len", 16'(busy_len), 16'd256);

        idle(); ena = 1'b1; addra = 9'h1FF;
        cycle();
        chk("cleared_1ff", 16'(doa[0]), 16'h0000);

        idle(); ena = 1'b1; wea = 1'b1; addra = 9'h010; dia = 8'h34;
        cycle();
        addra = 9'h011; dia = 8'h12;
        cycle();
        idle(); enb = 1'b1; addrb = 8'h08;
        cycle();
        chk("wide_read_u0", dob[0], 16'h1234);
        chk("wide_read_u2", dob[2], 16'h1234);
        idle();
        cycle();
        chk("wide_read_lat2_u1", dob[1], 16'h1234);

        idle(); enb = 1'b1; web = 2'b10; addrb = 8'h08; dib = 16'hABCD;
        cycle();
        chk("lane_wf_u0", dob[0], 16'hAB34);
        chk("lane_rf_u2", dob[2], 16'h1234);
        idle();
        cycle();
        chk("lane_nc_u1", dob[1], 16'h1234);

        idle(); ena = 1'b1; wea = 1'b1; addra = 9'h010; dia = 8'h55;
        enb = 1'b1; web = 2'b11; addrb = 8'h08; dib = 16'h9988;
        cycle();
        chk("coll_ww_u0", 16'(coll[0]), 16'h1);
        chk("coll_ww_u1", 16'(coll[1]), 16'h1);
        idle();
        cycle();
        chk("coll_pulse_u0", 16'(coll[0]), 16'h0);
        idle(); enb = 1'b1; addrb = 8'h08;
        cycle();
        chk("b_wins_u0", dob[0], 16'h9988);

        idle(); enb = 1'b1; web = 2'b11; addrb = 8'h08; dib = 16'h1234;
        cycle();
        idle(); ena = 1'b1; addra = 9'h011; enb = 1'b1; web = 2'b11; addrb = 8'h08; dib = 16'h7766;
        cycle();
        chk("coll_rd_doa_u0", 16'(doa[0]), 16'h0012);
        chk("coll_rd_doa_u2", 16'(doa[2]), 16'h0012);
        chk("coll_rw_u0", 16'(coll[0]), 16'h1);
        idle();
        cycle();
        chk("coll_rd_doa_u1", 16'(doa[1]), 16'h0012);

        idle(); ena = 1'b1; wea = 1'b1; rsta = 1'b1; addra = 9'h020; dia = 8'hFF;
        cycle();
        chk("rsta_doa_u0", 16'(doa[0]), 16'h0000);
        idle(); ena = 1'b1; addra = 9'h020;
        cycle();
        chk("rsta_wrote_u0", 16'(doa[0]), 16'h00FF);

        // random traffic concentrated on a few overlapping words to provoke collisions
        for (int i = 0; i < 400; i++) begin
            ena   = ($urandom_range(0, 3) != 0);
            wea   = 1'($urandom_range(0, 1));
            rsta  = ($urandom_range(0, 15) == 0);
            addra = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'(16 + $urandom_range(0, 7));
            dia   = 8'($urandom_range(0, 255));
            enb   = ($urandom_range(0, 3) != 0);
            web   = 2'($urandom_range(0, 3));
            rstb  = ($urandom_range(0, 15) == 0);
            addrb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(8 + $urandom_range(0, 3));
            dib   = 16'($urandom_range(0, 65535));
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
